// File: rtl/charmap_pkg.sv
// Shared definitions for the character map write-side controller.
// Holds the RAM target select codes, the default address width and the FSM state encoding.
package charmap_pkg;

   localparam int CHMAP_ADDR_W = 12;

   localparam logic [1:0] SEL_CHMAP = 2'd0;
   localparam logic [1:0] SEL_FGCOL = 2'd1;
   localparam logic [1:0] SEL_BGCOL = 2'd2;
   localparam logic [1:0] SEL_NONE  = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

endpackage

// File: rtl/charmap_wr_arb.sv
// Two-requester round-robin arbiter for the shared character map write port.
// On a conflict, the requester that was not granted last time wins. last_cpu resets to the fill side.
module charmap_wr_arb (
   input  logic clk,
   input  logic reset,
   input  logic req_cpu,
   input  logic req_fill,
   input  logic accept,
   output logic gnt_cpu,
   output logic gnt_fill
);

   logic last_cpu;

   always_comb begin
      gnt_cpu  = req_cpu & (~req_fill | ~last_cpu);
      gnt_fill = req_fill & ~gnt_cpu;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_cpu <= 1'b0;
      end else if (accept & (gnt_cpu | gnt_fill)) begin
         last_cpu <= gnt_cpu;
      end
   end

endmodule

// File: rtl/charmap_wr_ctrl.sv
// Write-side controller for the chmap/fgcol/bgcol RAMs.
// Shares the single RAM write port between CPU writes and a hardware screen-fill engine.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_IDLE | no fill running; only CPU writes are serviced
//   ST_FILL | fill engine writes cnt, sharing the port round-robin
module charmap_wr_ctrl
   import charmap_pkg::*;
#(
   parameter int ADDR_W     = CHMAP_ADDR_W,
   parameter int FILL_WORDS = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [1:0]        cpu_sel,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data,
   output logic              cpu_ack,
   input  logic              fill_start,
   input  logic [7:0]        fill_char,
   input  logic [7:0]        fill_fg,
   input  logic [7:0]        fill_bg,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              chmap_wr,
   output logic              fgcol_wr,
   output logic              bgcol_wr,
   output logic [7:0]        chmap_wdata,
   output logic [7:0]        fgcol_wdata,
   output logic [7:0]        bgcol_wdata
);

   // One extra bit so a full 2^ADDR_W fill reaches its terminal count without wrapping.
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(FILL_WORDS - 1);

   state_t          state, state_nxt;
   logic [ADDR_W:0] cnt;
   logic [7:0]      fill_char_q, fill_fg_q, fill_bg_q;
   logic            cpu_pend, fill_pend;
   logic            gnt_cpu, gnt_fill;
   logic            fill_last;

   // cpu_ack masks the request so a requester dropping req late cannot write twice.
   assign cpu_pend  = cpu_req & ~cpu_ack;
   assign fill_pend = (state == ST_FILL);

   charmap_wr_arb u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_cpu  (cpu_pend),
      .req_fill (fill_pend),
      .accept   (1'b1),
      .gnt_cpu  (gnt_cpu),
      .gnt_fill (gnt_fill)
   );

   always_comb begin
      state_nxt = state;
      fill_last = gnt_fill & (cnt == LAST_CNT);
      case (state)
         ST_IDLE: if (fill_start) state_nxt = ST_FILL;
         ST_FILL: if (fill_last)  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         fill_char_q <= '0;
         fill_fg_q   <= '0;
         fill_bg_q   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cpu_ack     <= 1'b0;
         ram_addr    <= '0;
         chmap_wr    <= 1'b0;
         fgcol_wr    <= 1'b0;
         bgcol_wr    <= 1'b0;
         chmap_wdata <= '0;
         fgcol_wdata <= '0;
         bgcol_wdata <= '0;
      end else begin
         state    <= state_nxt;
         // busy stays high through the done cycle and drops on the edge after it.
         busy     <= (state_nxt == ST_FILL) | fill_last;
         done     <= fill_last;
         cpu_ack  <= gnt_cpu;
         chmap_wr <= 1'b0;
         fgcol_wr <= 1'b0;
         bgcol_wr <= 1'b0;

         if ((state == ST_IDLE) && fill_start) begin
            fill_char_q <= fill_char;
            fill_fg_q   <= fill_fg;
            fill_bg_q   <= fill_bg;
            cnt         <= '0;
         end

         if (gnt_cpu) begin
            ram_addr <= cpu_addr;
            case (cpu_sel)
               SEL_CHMAP: begin chmap_wr <= 1'b1; chmap_wdata <= cpu_data; end
               SEL_FGCOL: begin fgcol_wr <= 1'b1; fgcol_wdata <= cpu_data; end
               SEL_BGCOL: begin bgcol_wr <= 1'b1; bgcol_wdata <= cpu_data; end
               SEL_NONE:  ;
            endcase
         end else if (gnt_fill) begin
            ram_addr    <= cnt[ADDR_W-1:0];
            chmap_wr    <= 1'b1;
            fgcol_wr    <= 1'b1;
            bgcol_wr    <= 1'b1;
            chmap_wdata <= fill_char_q;
            fgcol_wdata <= fill_fg_q;
            bgcol_wdata <= fill_bg_q;
            cnt         <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_charmap_wr_ctrl.sv
// Directed bench for charmap_wr_ctrl: reset, CPU writes, uncontested and contested fills, fill abort.
// A negedge monitor rebuilds the RAM contents from the strobes for image checks.
module tb_charmap_wr_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic [1:0]  cpu_sel = 2'd0;
   logic [11:0] cpu_addr = '0;
   logic [7:0]  cpu_data = '0;
   logic        fill_start = 1'b0;
   logic [7:0]  fill_char = '0, fill_fg = '0, fill_bg = '0;
   logic        cpu_ack, busy, done;
   logic [11:0] ram_addr;
   logic        chmap_wr, fgcol_wr, bgcol_wr;
   logic [7:0]  chmap_wdata, fgcol_wdata, bgcol_wdata;
   logic [2:0]  strb;

   assign strb = {chmap_wr, fgcol_wr, bgcol_wr};

   charmap_wr_ctrl #(.ADDR_W(12), .FILL_WORDS(4096)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_ack(cpu_ack),
      .fill_start(fill_start), .fill_char(fill_char), .fill_fg(fill_fg), .fill_bg(fill_bg),
      .busy(busy), .done(done), .ram_addr(ram_addr),
      .chmap_wr(chmap_wr), .fgcol_wr(fgcol_wr), .bgcol_wr(bgcol_wr),
      .chmap_wdata(chmap_wdata), .fgcol_wdata(fgcol_wdata), .bgcol_wdata(bgcol_wdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] ram_c [4096];
   logic [7:0] ram_f [4096];
   logic [7:0] ram_b [4096];
   logic [7:0] exp_c [4096];
   logic [7:0] exp_f [4096];
   logic [7:0] exp_b [4096];
   int busy_cnt = 0, done_cnt = 0, fill_wr_cnt = 0, rst_strobe_cnt = 0;

   always @(negedge clk) begin
      if (reset) begin
         if (strb != 3'b000) rst_strobe_cnt++;
      end else begin
         if (chmap_wr) ram_c[ram_addr] = chmap_wdata;
         if (fgcol_wr) ram_f[ram_addr] = fgcol_wdata;
         if (bgcol_wr) ram_b[ram_addr] = bgcol_wdata;
         if (strb == 3'b111) fill_wr_cnt++;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
   end

   initial begin : stim
      int errs, lerr, aerr, lat, b0, d0, fw, fw_prev, mism;
      logic got;
      logic [2:0] es;
      logic [7:0] kd;

      // Reset held with request inputs active
      cpu_req = 1'b1; cpu_sel = 2'd1; fill_start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_ctrl", {cpu_ack, busy, done, strb, ram_addr}, 32'h0);
         chk("reset_wdata", {chmap_wdata, fgcol_wdata, bgcol_wdata}, 32'h0);
      end
      reset = 1'b0; cpu_req = 1'b0; fill_start = 1'b0;
      @(negedge clk);
      chk("reset_no_strobe", rst_strobe_cnt, 0);

      // CPU write to fgcol, req held one cycle past ack
      cpu_req = 1'b1; cpu_sel = 2'd1; cpu_addr = 12'h0A5; cpu_data = 8'h3C;
      @(negedge clk);
      chk("cpu1_strobes", strb, 3'b010);
      chk("cpu1_addr", ram_addr, 12'h0A5);
      chk("cpu1_data", fgcol_wdata, 8'h3C);
      chk("cpu1_ack", cpu_ack, 1'b1);
      @(negedge clk);
      chk("cpu1_no_double", {cpu_ack, strb}, 4'h0);
      cpu_req = 1'b0;
      @(negedge clk);
      chk("cpu1_idle_hold", {ram_addr, fgcol_wdata}, {12'h0A5, 8'h3C});

      // Reserved select: ack only
      cpu_req = 1'b1; cpu_sel = 2'd3; cpu_addr = 12'h123; cpu_data = 8'h99;
      @(negedge clk);
      chk("sel3_ack", cpu_ack, 1'b1);
      chk("sel3_strobes", strb, 3'b000);
      cpu_req = 1'b0;
      @(negedge clk);

      // Uncontested full fill, with an ignored fill_start mid-fill
      b0 = busy_cnt; d0 = done_cnt;
      fill_char = 8'h20; fill_fg = 8'h07; fill_bg = 8'hFF; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      chk("fill_busy_start", busy, 1'b1);
      chk("fill_no_write_yet", strb, 3'b000);
      errs = 0;
      for (int n = 0; n < 4096; n++) begin
         @(negedge clk);
         if (strb !== 3'b111 || ram_addr !== 12'(n) ||
             {chmap_wdata, fgcol_wdata, bgcol_wdata} !== 24'h2007FF) errs++;
         if (n < 4095 && done !== 1'b0) errs++;
         if (n == 4095) chk("fill_done_last", done, 1'b1);
         if (n == 2000) begin fill_start = 1'b1; fill_char = 8'h55; end
         else fill_start = 1'b0;
      end
      chk("fill_sequence", errs, 0);
      @(negedge clk);
      chk("fill_end_quiet", {busy, done, strb}, 5'h0);
      chk("fill_busy_cycles", busy_cnt - b0, 4097);
      chk("fill_done_count", done_cnt - d0, 1);
      mism = 0;
      for (int a = 0; a < 4096; a++)
         if (ram_c[a] !== 8'h20 || ram_f[a] !== 8'h07 || ram_b[a] !== 8'hFF) mism++;
      chk("fill_image", mism, 0);

      // Fill with back-to-back CPU traffic to already-filled cells
      for (int a = 0; a < 4096; a++) begin
         exp_c[a] = 8'h41; exp_f[a] = 8'h12; exp_b[a] = 8'h34;
      end
      b0 = busy_cnt;
      fill_char = 8'h41; fill_fg = 8'h12; fill_bg = 8'h34; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 1000 && !got; i++) begin
         @(negedge clk);
         if (strb === 3'b111 && ram_addr === 12'd200) got = 1'b1;
      end
      chk("cf_reach_200", got, 1'b1);
      errs = 0; lerr = 0; aerr = 0; fw_prev = 0;
      for (int k = 0; k < 40; k++) begin
         cpu_req = 1'b1; cpu_sel = 2'(k % 3); cpu_addr = 12'(k); cpu_data = 8'h80 + 8'(k);
         kd = cpu_data;
         es = 3'b100 >> cpu_sel;
         got = 1'b0; lat = 0;
         for (int t = 1; t <= 4 && !got; t++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin got = 1'b1; lat = t; end
         end
         if (!got || lat > 2) lerr++;
         if (strb !== es || ram_addr !== 12'(k)) errs++;
         case (k % 3)
            0: begin if (chmap_wdata !== kd) errs++; exp_c[k] = kd; end
            1: begin if (fgcol_wdata !== kd) errs++; exp_f[k] = kd; end
            default: begin if (bgcol_wdata !== kd) errs++; exp_b[k] = kd; end
         endcase
         fw = fill_wr_cnt;
         if (k > 0 && fw - fw_prev != 1) aerr++;
         fw_prev = fw;
      end
      cpu_req = 1'b0;
      chk("cf_ack_latency", lerr, 0);
      chk("cf_cpu_writes", errs, 0);
      chk("cf_alternate", aerr, 0);
      got = 1'b0;
      for (int i = 0; i < 10000 && !got; i++) begin
         @(negedge clk);
         if (done === 1'b1) got = 1'b1;
      end
      chk("cf_done", got, 1'b1);
      @(negedge clk);
      chk("cf_busy_low", busy, 1'b0);
      chk("cf_busy_cycles", busy_cnt - b0, 4097 + 40);
      mism = 0;
      for (int a = 0; a < 4096; a++)
         if (ram_c[a] !== exp_c[a] || ram_f[a] !== exp_f[a] || ram_b[a] !== exp_b[a]) mism++;
      chk("cf_image", mism, 0);

      // Reset at fill address 1000 aborts the fill
      d0 = done_cnt;
      fill_char = 8'h66; fill_fg = 8'h77; fill_bg = 8'h88; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (strb === 3'b111 && ram_addr === 12'd1000) got = 1'b1;
      end
      chk("ab_reach_1000", got, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("ab_reset_outputs", {busy, done, strb, cpu_ack}, 6'h0);
      @(negedge clk);
      reset = 1'b0;
      chk("ab_no_done", done_cnt - d0, 0);

      // New fill restarts at address 0
      fill_char = 8'h11; fill_fg = 8'h22; fill_bg = 8'h33; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      chk("nf_busy", busy, 1'b1);
      @(negedge clk);
      chk("nf_first_strobes", strb, 3'b111);
      chk("nf_first_addr", ram_addr, 12'd0);
      chk("nf_first_data", {chmap_wdata, fgcol_wdata, bgcol_wdata}, 24'h112233);
      @(negedge clk);
      chk("nf_second_addr", ram_addr, 12'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
